// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and sprite shape encodings.
package vga_pkg;

  localparam int H_SYNC          = 96;
  localparam int H_BACK_PORCH    = 48;
  localparam int H_DISPLAY       = 640;
  localparam int H_FRONT_PORCH   = 16;
  localparam int H_TOTAL         = H_SYNC + H_BACK_PORCH + H_DISPLAY + H_FRONT_PORCH;
  localparam int H_DISPLAY_START = H_SYNC + H_BACK_PORCH;

  localparam int V_SYNC          = 2;
  localparam int V_BACK_PORCH    = 29;
  localparam int V_DISPLAY       = 480;
  localparam int V_FRONT_PORCH   = 10;
  localparam int V_TOTAL         = V_SYNC + V_BACK_PORCH + V_DISPLAY + V_FRONT_PORCH;
  localparam int V_DISPLAY_START = V_SYNC + V_BACK_PORCH;

  typedef enum logic [1:0] {
    MODE_TRI     = 2'd0,
    MODE_RECT    = 2'd1,
    MODE_DIAMOND = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

endpackage

// File: rtl/switch_debouncer.sv
// One switch: 2-FF synchroniser followed by a stable-count debouncer.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;

  // bring the asynchronous switch into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_sw};
  end

  // accept a new level only after it has been seen for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync[1] == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt <= '0;
      r_db  <= r_sync[1];
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/vga_sprite_controller.sv
// Switch-driven sprite: debounced movement once per N frames, per-pixel shape test.
module vga_sprite_controller import vga_pkg::*; #(
  parameter int H_DISPLAY       = vga_pkg::H_DISPLAY,
  parameter int V_DISPLAY       = vga_pkg::V_DISPLAY,
  parameter int H_DISPLAY_START = vga_pkg::H_DISPLAY_START,
  parameter int V_DISPLAY_START = vga_pkg::V_DISPLAY_START,
  parameter int HALF_W          = 75,
  parameter int HALF_H          = 50,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_MOVE = 1,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_sw,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_h_count,
  input  logic [15:0] i_v_count,
  output logic        o_pixel_on,
  output logic [9:0]  o_center_x,
  output logic [9:0]  o_center_y,
  output logic [3:0]  o_at_edge
);

  localparam int X_MIN = HALF_W;
  localparam int X_MAX = H_DISPLAY - 1 - HALF_W;
  localparam int Y_MIN = HALF_H;
  localparam int Y_MAX = V_DISPLAY - 1 - HALF_H;
  localparam int FW    = $clog2(FRAMES_PER_MOVE + 1);

  logic [3:0]    w_sw_db;
  logic [9:0]    r_cx, r_cy;
  logic [FW-1:0] r_frame_cnt;
  mode_e         r_mode;
  logic          r_pixel_on;

  logic          w_tick, w_move, w_visible, w_inside;
  int            w_cx_i, w_cy_i, w_nx, w_ny;
  int            w_x, w_y, w_dx, w_dy, w_ady;

  // one debouncer per direction switch
  for (genvar g = 0; g < 4; g++) begin : g_db
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_sw  (i_sw[g]),
      .o_db  (w_sw_db[g])
    );
  end

  assign w_tick = (i_h_count == 16'd0) && (i_v_count == 16'd0);
  assign w_move = w_tick && (r_frame_cnt == FW'(FRAMES_PER_MOVE - 1));

  // next centre: opposing switches cancel, clamps done in signed int so cx-STEP cannot wrap
  always_comb begin
    w_cx_i = {22'd0, r_cx};
    w_cy_i = {22'd0, r_cy};
    w_nx   = w_cx_i;
    w_ny   = w_cy_i;
    if (w_sw_db[0] && !w_sw_db[1])
      w_nx = (w_cx_i - STEP < X_MIN) ? X_MIN : w_cx_i - STEP;
    else if (w_sw_db[1] && !w_sw_db[0])
      w_nx = (w_cx_i + STEP > X_MAX) ? X_MAX : w_cx_i + STEP;
    if (w_sw_db[2] && !w_sw_db[3])
      w_ny = (w_cy_i - STEP < Y_MIN) ? Y_MIN : w_cy_i - STEP;
    else if (w_sw_db[3] && !w_sw_db[2])
      w_ny = (w_cy_i + STEP > Y_MAX) ? Y_MAX : w_cy_i + STEP;
  end

  // frame counter, centre update on move ticks, mode latch on every tick (tear-free)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
      r_cx        <= 10'(H_DISPLAY / 2);
      r_cy        <= 10'(V_DISPLAY / 2);
      r_mode      <= MODE_TRI;
    end else if (w_tick) begin
      r_mode <= mode_e'(i_mode);
      if (w_move) begin
        r_frame_cnt <= '0;
        r_cx        <= 10'(w_nx);
        r_cy        <= 10'(w_ny);
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  // shape membership in exact integer arithmetic relative to the centre
  always_comb begin
    w_x       = {16'd0, i_h_count} - H_DISPLAY_START;
    w_y       = {16'd0, i_v_count} - V_DISPLAY_START;
    w_dx      = (w_x >= w_cx_i) ? (w_x - w_cx_i) : (w_cx_i - w_x);
    w_dy      = w_y - w_cy_i;
    w_ady     = (w_dy < 0) ? -w_dy : w_dy;
    w_visible = (i_h_count >= 16'(H_DISPLAY_START)) &&
                (i_h_count <  16'(H_DISPLAY_START + H_DISPLAY)) &&
                (i_v_count >= 16'(V_DISPLAY_START)) &&
                (i_v_count <  16'(V_DISPLAY_START + V_DISPLAY));
    w_inside  = 1'b0;
    case (r_mode)
      MODE_TRI:     w_inside = (w_ady <= HALF_H) &&
                               (w_dx * 2 * HALF_H <= (w_dy + HALF_H) * HALF_W);
      MODE_RECT:    w_inside = (w_dx <= HALF_W) && (w_ady <= HALF_H);
      MODE_DIAMOND: w_inside = (w_dx * HALF_H + w_ady * HALF_W <= HALF_W * HALF_H);
      default:      w_inside = 1'b0;
    endcase
  end

  // one-cycle pixel latency; downstream delays sync by one to match
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pixel_on <= 1'b0;
    else       r_pixel_on <= w_visible && w_inside;
  end

  assign o_pixel_on = r_pixel_on;
  assign o_center_x = r_cx;
  assign o_center_y = r_cy;
  assign o_at_edge  = {(r_cy == 10'(Y_MAX)), (r_cy == 10'(Y_MIN)),
                       (r_cx == 10'(X_MAX)), (r_cx == 10'(X_MIN))};

endmodule

// File: tb/tb_vga_sprite_controller.sv
// Directed bench: reset, shapes, mode latching, debounce, movement and clamping.
module tb_vga_sprite_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic [1:0]  mode;
  logic [15:0] h, v;
  logic        pixel_on;
  logic [9:0]  cx, cy;
  logic [3:0]  at_edge;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;
  int exp_cx;
  logic seen;

  always #5 clk = ~clk;

  vga_sprite_controller #(
    .DEBOUNCE_CYCLES (4),
    .FRAMES_PER_MOVE (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw       (sw),
    .i_mode     (mode),
    .i_h_count  (h),
    .i_v_count  (v),
    .o_pixel_on (pixel_on),
    .o_center_x (cx),
    .o_center_y (cy),
    .o_at_edge  (at_edge)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int hh, input int vv);
    @(negedge clk);
    h = 16'(hh);
    v = 16'(vv);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0);
  endtask

  // abbreviated frame: one tick cycle then one blanking cycle
  task automatic frame();
    drive(0, 0);
    ticks++;
    drive(1, 0);
  endtask

  task automatic pix_raw(input int hh, input int vv, input logic e, input string tag);
    drive(hh, vv);
    @(posedge clk);
    #1;
    check(tag, {31'd0, pixel_on}, {31'd0, e});
  endtask

  task automatic pix(input int x, input int y, input logic e, input string tag);
    pix_raw(x + 144, y + 31, e, tag);
  endtask

  initial begin
    rst = 1'b1; sw = 4'b0; mode = 2'd0; h = 16'd1; v = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_cx", cx, 320);
    check("rst_cy", cy, 240);
    check("rst_pix", pixel_on, 0);
    check("rst_edge", at_edge, 0);
    @(negedge clk);
    rst = 1'b0;

    // rectangle, including one-cycle latency
    mode = 2'd1; frame();
    drive(395 + 144, 290 + 31);
    #1 check("lat_before_edge", pixel_on, 0);
    @(posedge clk); #1;
    check("rect_corner_in", pixel_on, 1);
    pix(396, 290, 0, "rect_right_out");
    pix(320, 291, 0, "rect_below_out");
    pix_raw(143, 271, 0, "invisible_h");

    // triangle and diamond
    mode = 2'd0; frame();
    pix(320, 190, 1, "tri_tip_in");
    pix(321, 190, 0, "tri_tip_out");
    pix(245, 290, 1, "tri_base_in");
    pix(244, 290, 0, "tri_base_out");
    mode = 2'd2; frame();
    pix(395, 240, 1, "dia_right_in");
    pix(320, 291, 0, "dia_below_out");
    pix(320, 290, 1, "dia_bottom_in");

    // sprite off: sweep the sprite area
    mode = 2'd3; frame();
    seen = 1'b0;
    for (int y = 190; y <= 290; y += 10)
      for (int x = 245; x <= 395; x += 10) begin
        drive(x + 144, y + 31);
        @(posedge clk); #1;
        seen = seen | pixel_on;
      end
    check("off_never_on", seen, 0);

    // mode change mid-frame only takes effect at the next tick
    mode = 2'd0; frame();
    pix(395, 240, 0, "tri_side_out");
    drive(200, 200);
    mode = 2'd1;
    pix(395, 240, 0, "midframe_still_tri");
    frame();
    pix(395, 240, 1, "next_frame_rect");

    // up+down cancel
    sw = 4'b1100; idle(10);
    repeat (10) frame();
    check("updown_cy", cy, 240);
    check("updown_cx", cx, 320);
    sw = 4'b0000; idle(10);

    // 2-cycle glitch is rejected
    sw = 4'b0001; idle(2);
    sw = 4'b0000; idle(10);
    repeat (10) frame();
    check("glitch_cx", cx, 320);

    // move right to the clamp; no movement without a tick
    sw = 4'b0010; idle(20);
    check("no_tick_no_move", cx, 320);
    exp_cx = 320;
    for (int i = 0; i < 500; i++) begin
      frame();
      if (ticks % 2 == 0 && exp_cx < 564) exp_cx++;
      check("right_step", cx, exp_cx);
    end
    check("right_clamp", cx, 564);
    check("right_edge", at_edge, 4'b0010);
    check("right_cy", cy, 240);

    // move left to the clamp
    sw = 4'b0001; idle(10);
    for (int i = 0; i < 1000; i++) begin
      frame();
      if (ticks % 2 == 0 && exp_cx > 75) exp_cx--;
      check("left_step", cx, exp_cx);
    end
    check("left_clamp", cx, 75);
    check("left_edge", at_edge, 4'b0001);

    // asynchronous reset between clock edges
    sw = 4'b0000;
    pix(75, 240, 1, "rect_at_left_clamp");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cx", cx, 320);
    check("async_rst_cy", cy, 240);
    check("async_rst_pix", pixel_on, 0);
    check("async_rst_edge", at_edge, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
